// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter sharing one byte-serial transmitter (load/send/tx_end) among NREQ producers.
// Optional WAIT_END watchdog is enabled by defining SERIAL_TX_ARB_WATCHDOG_EN.
module serial_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int WD_CYCLES = 2047
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic                dsr,
    input  logic                tx_end,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                err,
    output logic                tx_load,
    output logic                tx_send,
    output logic [7:0]          tx_data,
    output logic                busy,
    output logic                timeout,
    output logic [15:0]         tx_count
);

    localparam int          PW = $clog2(NREQ);
    localparam int unsigned NU = NREQ;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("serial_tx_arbiter: NREQ must be 2..8");
    end
    if (WD_CYCLES < 1 || WD_CYCLES > 65535) begin : g_bad_wd
        $error("serial_tx_arbiter: WD_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {IDLE, LOAD, SEND, WAIT_END} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [PW-1:0]   sel, cand;
    logic            sel_valid;
    logic            wd_hit;
    logic [NREQ-1:0] owner_oh;

    logic [NREQ-1:0] grant_nxt, done_nxt;
    logic            err_nxt, tx_load_nxt, tx_send_nxt, busy_nxt, timeout_nxt;
    logic [7:0]      tx_data_nxt;
    logic [15:0]     tx_count_nxt;

    assign owner_oh = NREQ'(1) << owner;

    // Scan downward so the last hit is the nearest requester above the pointer.
    always_comb begin
        sel       = ptr;
        sel_valid = 1'b0;
        cand      = '0;
        for (int unsigned i = NU; i >= 1; i--) begin
            cand = PW'((32'(ptr) + i) % NU);
            if (req[cand]) begin
                sel       = cand;
                sel_valid = 1'b1;
            end
        end
    end

`ifdef SERIAL_TX_ARB_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(WD_CYCLES - 1);
    logic [15:0] wd_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            wd_cnt <= '0;
        else if (state != WAIT_END)
            wd_cnt <= '0;
        else if (!tx_end)
            wd_cnt <= wd_cnt + 16'd1;
    end

    // tx_end takes precedence over expiry in the same cycle.
    always_comb wd_hit = (state == WAIT_END) && !tx_end && (wd_cnt == WD_LAST);
`else
    always_comb wd_hit = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= PW'(NREQ - 1);
            owner    <= '0;
            grant    <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_load  <= 1'b0;
            tx_send  <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            tx_count <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            grant    <= grant_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            tx_load  <= tx_load_nxt;
            tx_send  <= tx_send_nxt;
            tx_data  <= tx_data_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
            tx_count <= tx_count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (sel_valid) state_nxt = LOAD;
            LOAD:     state_nxt = dsr ? SEND : IDLE;
            SEND:     state_nxt = WAIT_END;
            WAIT_END: if (tx_end || wd_hit) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        grant_nxt    = grant;
        done_nxt     = '0;
        err_nxt      = 1'b0;
        tx_load_nxt  = 1'b0;
        tx_send_nxt  = 1'b0;
        tx_data_nxt  = tx_data;
        timeout_nxt  = 1'b0;
        tx_count_nxt = tx_count;
        busy_nxt     = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    owner_nxt   = sel;
                    grant_nxt   = NREQ'(1) << sel;
                    tx_data_nxt = req_data[{sel, 3'b000} +: 8];
                    tx_load_nxt = 1'b1;
                end
            end
            LOAD: begin
                if (dsr) begin
                    tx_send_nxt = 1'b1;
                end else begin
                    done_nxt  = owner_oh;
                    err_nxt   = 1'b1;
                    grant_nxt = '0;
                    ptr_nxt   = owner;
                end
            end
            SEND: ;
            WAIT_END: begin
                if (tx_end) begin
                    done_nxt     = owner_oh;
                    grant_nxt    = '0;
                    ptr_nxt      = owner;
                    tx_count_nxt = tx_count + 16'd1;
                end else if (wd_hit) begin
                    done_nxt    = owner_oh;
                    err_nxt     = 1'b1;
                    timeout_nxt = 1'b1;
                    grant_nxt   = '0;
                    ptr_nxt     = owner;
                end
            end
            default: ;
        endcase
    end

endmodule
